// File: rtl/ahb_qspi_flash_writer_pkg.sv
// Shared definitions for the AHB QSPI flash writer: register map, WE key,
// bit positions and the shift engine state type.
package ahb_qspi_flash_writer_pkg;

  localparam logic [7:0] ADDR_WE     = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h04;
  localparam logic [7:0] ADDR_CLKDIV = 8'h08;
  localparam logic [7:0] ADDR_TXDATA = 8'h0C;
  localparam logic [7:0] ADDR_RXDATA = 8'h10;
  localparam logic [7:0] ADDR_STATUS = 8'h14;
  localparam logic [7:0] ADDR_ID     = 8'h18;

  localparam logic [23:0] WE_KEY = 24'hA5A855;

  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_DONE = 1;
  localparam int unsigned STATUS_OVR  = 2;

  localparam int unsigned CTRL_SS   = 0;
  localparam int unsigned CTRL_QUAD = 1;
  localparam int unsigned CTRL_QDIR = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_FIN  = 2'd3
  } eng_state_e;

  // Lane value presented for the current top of the shift register.
  function automatic logic [3:0] lane_out(input logic [7:0] sh, input logic quad);
    return quad ? sh[7:4] : {3'b000, sh[7]};
  endfunction

endpackage

// File: rtl/ahb_qspi_flash_writer_if.sv
// AHB-Lite slave-side signal bundle for the flash writer.
interface ahb_qspi_flash_writer_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY
  );
endinterface

// File: rtl/qspi_shift_engine.sv
// One-byte SPI mode-0 shift engine, single or quad lane, MSB first, with a
// programmable SCK half-period of div+1 clock cycles.
module qspi_shift_engine
  import ahb_qspi_flash_writer_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       tx,
  input  logic             quad,
  input  logic             qdir,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  input  logic [3:0]       din,
  output logic             sck,
  output logic [3:0]       dout,
  output logic [3:0]       douten,
  output logic [7:0]       rx,
  output logic             busy,
  output logic             done_pulse
);

  eng_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       per_q, per_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rxsh_q, rxsh_d;
  logic [7:0]       rx_q, rx_d;
  logic [3:0]       dout_q, dout_d;
  logic [3:0]       douten_q, douten_d;
  logic             sck_q, sck_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       last_per_c;

  assign last_per_c = quad ? 3'd1 : 3'd7;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      sh_q     <= '0;
      rxsh_q   <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      douten_q <= '0;
      sck_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      sh_q     <= sh_d;
      rxsh_q   <= rxsh_d;
      rx_q     <= rx_d;
      dout_q   <= dout_d;
      douten_q <= douten_d;
      sck_q    <= sck_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state: counter compares before incrementing so div=max never wraps early.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    sh_d     = sh_q;
    rxsh_d   = rxsh_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    douten_d = 4'b0000;
    sck_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          per_d   = '0;
          sh_d    = tx;
          dout_d  = lane_out(tx, quad);
        end
      end
      ST_LOW: begin
        if (cnt_q == div) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          rxsh_d  = quad ? {rxsh_q[3:0], din} : {rxsh_q[6:0], din[1]};
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_q == div) begin
          cnt_d = '0;
          if (per_q == last_per_c) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_LOW;
            per_d   = per_q + 3'd1;
            sh_d    = quad ? {sh_q[3:0], 4'b0000} : {sh_q[6:0], 1'b0};
            dout_d  = lane_out(sh_d, quad);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        rx_d    = rxsh_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      rx_d    = rx_q;
    end

    sck_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    if (state_d != ST_IDLE) begin
      douten_d = quad ? (qdir ? 4'b0000 : 4'b1111) : 4'b0001;
    end else begin
      douten_d = (quad && !qdir) ? 4'b1111 : 4'b0000;
    end
  end

  assign sck        = sck_q;
  assign dout       = dout_q;
  assign douten     = douten_q;
  assign rx         = rx_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;

endmodule

// File: rtl/ahb_qspi_flash_writer.sv
// AHB-Lite register front end and flash pin mux: reader passthrough while
// WE=0, hardware shift engine on the pins while WE=1.
module ahb_qspi_flash_writer
  import ahb_qspi_flash_writer_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DIV_RST  = 2,
  parameter logic [31:0] ID_VALUE = 32'hABCD0002
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  ahb_qspi_flash_writer_if.slave  ahb,
  input  logic                    fr_sck,
  input  logic                    fr_ce_n,
  output logic [3:0]              fr_din,
  input  logic [3:0]              fr_dout,
  input  logic                    fr_douten,
  output logic                    fm_sck,
  output logic                    fm_ce_n,
  input  logic [3:0]              fm_din,
  output logic [3:0]              fm_dout,
  output logic [3:0]              fm_douten
);

  logic             ap_valid_q, ap_valid_d;
  logic             ap_write_q, ap_write_d;
  logic [7:0]       ap_addr_q, ap_addr_d;
  logic             we_q, we_d;
  logic             ss_q, ss_d;
  logic             quad_q, quad_d;
  logic             qdir_q, qdir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic             start_c;
  logic             ovr_set_c;
  logic             wr_c;
  logic [2:0]       status_c;
  logic [31:0]      hrdata_c;

  logic             eng_sck;
  logic [3:0]       eng_dout;
  logic [3:0]       eng_douten;
  logic [7:0]       eng_rx;
  logic             eng_busy;
  logic             eng_done;

  logic             unused_ok;
  assign unused_ok = ^{ahb.HADDR[31:8], ahb.HTRANS[0], ahb.HSIZE};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ap_valid_q <= 1'b0;
      ap_write_q <= 1'b0;
      ap_addr_q  <= '0;
      we_q       <= 1'b0;
      ss_q       <= 1'b1;
      quad_q     <= 1'b0;
      qdir_q     <= 1'b0;
      div_q      <= DIV_W'(DIV_RST);
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ap_valid_q <= ap_valid_d;
      ap_write_q <= ap_write_d;
      ap_addr_q  <= ap_addr_d;
      we_q       <= we_d;
      ss_q       <= ss_d;
      quad_q     <= quad_d;
      qdir_q     <= qdir_d;
      div_q      <= div_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  // Address phase capture and data-phase register writes.
  always_comb begin
    ap_valid_d = ahb.HSEL & ahb.HTRANS[1];
    ap_write_d = ahb.HWRITE;
    ap_addr_d  = ahb.HADDR[7:0];
    we_d       = we_q;
    ss_d       = ss_q;
    quad_d     = quad_q;
    qdir_d     = qdir_q;
    div_d      = div_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    start_c    = 1'b0;
    ovr_set_c  = 1'b0;
    wr_c       = ap_valid_q & ap_write_q;

    if (wr_c) begin
      case (ap_addr_q)
        ADDR_WE: begin
          if (ahb.HWDATA[31:8] == WE_KEY) we_d = ahb.HWDATA[0];
        end
        ADDR_CTRL: begin
          if (eng_busy) begin
            ovr_set_c = 1'b1;
          end else begin
            ss_d   = ahb.HWDATA[CTRL_SS];
            quad_d = ahb.HWDATA[CTRL_QUAD];
            qdir_d = ahb.HWDATA[CTRL_QDIR];
          end
        end
        ADDR_CLKDIV: begin
          if (eng_busy) ovr_set_c = 1'b1;
          else          div_d     = ahb.HWDATA[DIV_W-1:0];
        end
        ADDR_TXDATA: begin
          if (eng_busy || !we_q) ovr_set_c = 1'b1;
          else                   start_c   = 1'b1;
        end
        ADDR_STATUS: begin
          if (ahb.HWDATA[STATUS_DONE]) done_d = 1'b0;
          if (ahb.HWDATA[STATUS_OVR])  ovr_d  = 1'b0;
        end
        default: ;
      endcase
    end

    if (ovr_set_c) ovr_d = 1'b1;
    if (start_c)   done_d = 1'b0;
    // A completion racing a W1C still lands; an aborted one never does.
    if (eng_done && we_d) done_d = 1'b1;
  end

  always_comb begin
    status_c              = 3'b000;
    status_c[STATUS_BUSY] = eng_busy;
    status_c[STATUS_DONE] = done_q;
    status_c[STATUS_OVR]  = ovr_q;
    hrdata_c              = '0;
    if (ap_valid_q && !ap_write_q) begin
      case (ap_addr_q)
        ADDR_WE:     hrdata_c = 32'(we_q);
        ADDR_CTRL:   hrdata_c = 32'({qdir_q, quad_q, ss_q});
        ADDR_CLKDIV: hrdata_c = 32'(div_q);
        ADDR_RXDATA: hrdata_c = 32'(eng_rx);
        ADDR_STATUS: hrdata_c = 32'(status_c);
        ADDR_ID:     hrdata_c = ID_VALUE;
        default:     hrdata_c = '0;
      endcase
    end
  end

  assign ahb.HRDATA = hrdata_c;
  assign ahb.HREADY = 1'b1;

  qspi_shift_engine #(.DIV_W(DIV_W)) u_eng (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .start      (start_c),
    .tx         (ahb.HWDATA[7:0]),
    .quad       (quad_q),
    .qdir       (qdir_q),
    .div        (div_q),
    .abort      (!we_d),
    .din        (fm_din),
    .sck        (eng_sck),
    .dout       (eng_dout),
    .douten     (eng_douten),
    .rx         (eng_rx),
    .busy       (eng_busy),
    .done_pulse (eng_done)
  );

  assign fm_sck    = we_q ? eng_sck    : fr_sck;
  assign fm_ce_n   = we_q ? ss_q       : fr_ce_n;
  assign fm_dout   = we_q ? eng_dout   : fr_dout;
  assign fm_douten = we_q ? eng_douten : {4{fr_douten}};
  assign fr_din    = fm_din;

endmodule

// File: tb/tb_ahb_qspi_flash_writer.sv
// Directed bench for ahb_qspi_flash_writer: register access, single/quad
// transfers, overrun, abort and mid-transfer reset.
module tb_ahb_qspi_flash_writer;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       fr_sck, fr_ce_n, fr_douten;
  logic [3:0] fr_din, fr_dout;
  logic       fm_sck, fm_ce_n;
  logic [3:0] fm_din, fm_dout, fm_douten;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  ahb_qspi_flash_writer_if ahb ();

  ahb_qspi_flash_writer #(
    .DIV_W    (8),
    .DIV_RST  (2),
    .ID_VALUE (32'hABCD0002)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ahb       (ahb),
    .fr_sck    (fr_sck),
    .fr_ce_n   (fr_ce_n),
    .fr_din    (fr_din),
    .fr_dout   (fr_dout),
    .fr_douten (fr_douten),
    .fm_sck    (fm_sck),
    .fm_ce_n   (fm_ce_n),
    .fm_din    (fm_din),
    .fm_dout   (fm_dout),
    .fm_douten (fm_douten)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b1;
    ahb.HADDR  = {24'h0, a};
    @(posedge HCLK); #1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    ahb.HWDATA = d;
  endtask

  task automatic ahb_rd(input logic [7:0] a, output logic [31:0] d);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = {24'h0, a};
    @(posedge HCLK); #1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    d = ahb.HRDATA;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK); #1;
    end
  endtask

  function automatic logic [3:0] din_for(input logic quad, input logic [7:0] pat, input int idx);
    logic [7:0] p;
    p = pat;
    if (quad) return (idx == 0) ? p[7:4] : p[3:0];
    if (idx > 7) return 4'h0;
    return {2'b00, p[7-idx], 1'b0};
  endfunction

  // Follows one transfer from its first busy cycle to the first idle cycle.
  task automatic run_xfer(input logic quad, input logic [7:0] rxpat,
                          output logic [7:0] txs, output int busy_n,
                          output int hmin, output int hmax, output logic [3:0] oe);
    int   rises;
    int   run;
    logic prev;
    rises = 0; run = 0; prev = 1'b0;
    txs = 8'h00; busy_n = 0; hmin = 100000; hmax = 0; oe = 4'hx;
    fm_din = din_for(quad, rxpat, 0);
    for (int c = 0; c < 2000; c++) begin
      @(posedge HCLK); #1;
      if (!dut.eng_busy) break;
      busy_n++;
      if (fm_sck) begin
        run++;
        if (!prev) begin
          if (rises == 0) oe = fm_douten;
          txs = quad ? {txs[3:0], fm_dout} : {txs[6:0], fm_dout[0]};
          rises++;
        end
      end else begin
        if (prev) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
          run = 0;
        end
        fm_din = din_for(quad, rxpat, rises);
      end
      prev = fm_sck;
    end
  endtask

  logic [7:0]  txs;
  logic [3:0]  oe;
  int          busy_n, hmin, hmax;

  initial begin
    HRESETn    = 1'b0;
    ahb.HSEL   = 1'b0;
    ahb.HADDR  = '0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    ahb.HSIZE  = 3'b010;
    ahb.HWDATA = '0;
    fr_sck = 1'b0; fr_ce_n = 1'b1; fr_dout = 4'h0; fr_douten = 1'b0;
    fm_din = 4'h0;
    idle(3);
    HRESETn = 1'b1;
    idle(1);

    // 1: reset values, bad key, passthrough
    check("rst_hrdata", ahb.HRDATA, 32'h0);
    check("rst_hready", 32'(ahb.HREADY), 32'h1);
    rd_check("rst_we", 8'h00, 32'h0);
    rd_check("rst_ctrl", 8'h04, 32'h1);
    rd_check("rst_clkdiv", 8'h08, 32'h2);
    rd_check("rst_status", 8'h14, 32'h0);
    rd_check("rst_rxdata", 8'h10, 32'h0);
    rd_check("id", 8'h18, 32'hABCD0002);
    ahb_wr(8'h00, 32'h12345601);
    rd_check("we_badkey", 8'h00, 32'h0);
    fr_sck = 1'b1; fr_douten = 1'b1; fr_ce_n = 1'b0; fr_dout = 4'hA; fm_din = 4'h5;
    #1;
    check("pass_sck1", 32'(fm_sck), 32'h1);
    check("pass_douten", 32'(fm_douten), 32'hF);
    check("pass_ce_n", 32'(fm_ce_n), 32'h0);
    check("pass_dout", 32'(fm_dout), 32'hA);
    check("pass_fr_din", 32'(fr_din), 32'h5);
    fr_sck = 1'b0;
    #1;
    check("pass_sck0", 32'(fm_sck), 32'h0);

    // 2: single mode, CLKDIV=0
    ahb_wr(8'h00, 32'hA5A85501);
    ahb_wr(8'h04, 32'h0);
    ahb_wr(8'h08, 32'h0);
    rd_check("we_goodkey", 8'h00, 32'h1);
    ahb_wr(8'h0C, 32'hA5);
    run_xfer(1'b0, 8'h3C, txs, busy_n, hmin, hmax, oe);
    check("s_tx", 32'(txs), 32'hA5);
    check("s_busy", 32'(busy_n), 32'd17);
    check("s_oe", 32'(oe), 32'h1);
    check("s_hi", 32'(hmax), 32'd1);
    check("s_ce_n", 32'(fm_ce_n), 32'h0);
    check("s_idle_sck", 32'(fm_sck), 32'h0);
    rd_check("s_rx", 8'h10, 32'h3C);
    rd_check("s_status", 8'h14, 32'h2);

    // 3: quad write, CLKDIV=3
    ahb_wr(8'h04, 32'h2);
    ahb_wr(8'h08, 32'h3);
    ahb_wr(8'h0C, 32'h9E);
    run_xfer(1'b1, 8'h00, txs, busy_n, hmin, hmax, oe);
    check("qw_tx", 32'(txs), 32'h9E);
    check("qw_busy", 32'(busy_n), 32'd17);
    check("qw_oe", 32'(oe), 32'hF);
    check("qw_hmin", 32'(hmin), 32'd4);
    check("qw_hmax", 32'(hmax), 32'd4);
    check("qw_idle_oe", 32'(fm_douten), 32'hF);

    // 3b: CLKDIV at maximum
    ahb_wr(8'h08, 32'hFF);
    ahb_wr(8'h0C, 32'h3C);
    run_xfer(1'b1, 8'h00, txs, busy_n, hmin, hmax, oe);
    check("qmax_tx", 32'(txs), 32'h3C);
    check("qmax_busy", 32'(busy_n), 32'd1025);
    check("qmax_hmin", 32'(hmin), 32'd256);

    // 4: quad read
    ahb_wr(8'h04, 32'h6);
    ahb_wr(8'h08, 32'h3);
    ahb_wr(8'h0C, 32'h00);
    run_xfer(1'b1, 8'h7B, txs, busy_n, hmin, hmax, oe);
    check("qr_oe", 32'(oe), 32'h0);
    check("qr_busy", 32'(busy_n), 32'd17);
    check("qr_idle_oe", 32'(fm_douten), 32'h0);
    rd_check("qr_rx", 8'h10, 32'h7B);

    // 5: TXDATA while busy, then W1C
    ahb_wr(8'h04, 32'h0);
    ahb_wr(8'h0C, 32'h55);
    ahb_wr(8'h0C, 32'hFF);
    run_xfer(1'b0, 8'hC3, txs, busy_n, hmin, hmax, oe);
    check("ovr_tx", 32'(txs), 32'h55);
    rd_check("ovr_status", 8'h14, 32'h6);
    rd_check("ovr_rx", 8'h10, 32'hC3);
    ahb_wr(8'h14, 32'h6);
    rd_check("w1c_status", 8'h14, 32'h0);

    // 6: clear WE mid-transfer
    ahb_wr(8'h0C, 32'h81);
    idle(10);
    ahb_wr(8'h00, 32'hA5A85500);
    idle(1);
    check("abort_busy", 32'(dut.eng_busy), 32'h0);
    fr_sck = 1'b1; fr_douten = 1'b1;
    #1;
    check("abort_sck", 32'(fm_sck), 32'h1);
    check("abort_douten", 32'(fm_douten), 32'hF);
    rd_check("abort_status", 8'h14, 32'h0);
    rd_check("abort_rx", 8'h10, 32'hC3);
    fr_sck = 1'b0; fr_douten = 1'b0;

    // 6b: reset mid-transfer
    ahb_wr(8'h00, 32'hA5A85501);
    ahb_wr(8'h04, 32'h3);
    ahb_wr(8'h08, 32'h5);
    ahb_wr(8'h0C, 32'h12);
    idle(5);
    check("pre_rst_busy", 32'(dut.eng_busy), 32'h1);
    HRESETn = 1'b0;
    idle(1);
    HRESETn = 1'b1;
    check("mrst_busy", 32'(dut.eng_busy), 32'h0);
    check("mrst_hrdata", ahb.HRDATA, 32'h0);
    check("mrst_eng_dout", 32'(dut.eng_dout), 32'h0);
    fr_sck = 1'b1;
    #1;
    check("mrst_pass_sck", 32'(fm_sck), 32'h1);
    fr_sck = 1'b0;
    rd_check("mrst_we", 8'h00, 32'h0);
    rd_check("mrst_ctrl", 8'h04, 32'h1);
    rd_check("mrst_clkdiv", 8'h08, 32'h2);
    rd_check("mrst_status", 8'h14, 32'h0);
    rd_check("mrst_rx", 8'h10, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
